// File: rtl/srp16_pkg.sv
`default_nettype none
// ============================================================================
// Module      : srp16_pkg
// Description : Shared constants for the SRP16 boot loader: loader state
//               encoding and the err_code values reported on an abort.
// Revision    : 1.0 - initial release
// ============================================================================
package srp16_pkg;

    // Loader state encoding (explicit 3-bit width)
    localparam int         STATE_W = 3;
    localparam logic [2:0] LEN_LO  = 3'd0;
    localparam logic [2:0] LEN_HI  = 3'd1;
    localparam logic [2:0] PAYLOAD = 3'd2;
    localparam logic [2:0] CHECK   = 3'd3;
    localparam logic [2:0] RUN     = 3'd4;
    localparam logic [2:0] ERROR   = 3'd5;

    // err_code values
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CSUM    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage
`default_nettype wire

// File: rtl/srp16_boot_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : srp16_boot_loader_if
// Description : Byte-stream receive handshake plus program-memory write port
//               of the SRP16 boot loader.
//               rx_data/rx_valid/rx_ready : byte stream, transfer on
//                                           rx_valid && rx_ready at clk edge
//               mem_addr/mem_data/mem_write : one-cycle write strobe
//               modport slave  : the loader side
//               modport master : the byte source / memory side
// Revision    : 1.0 - initial release
// ============================================================================
interface srp16_boot_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_write;

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output mem_addr,
        output mem_data,
        output mem_write
    );

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  mem_addr,
        input  mem_data,
        input  mem_write
    );
endinterface
`default_nettype wire

// File: rtl/srp16_boot_timeout.sv
`default_nettype none
// ============================================================================
// Module      : srp16_boot_timeout
// Description : Idle counter for the boot loader. Counts cycles while i_run
//               is high and no byte is accepted; i_clear (an accept) or
//               i_run low returns it to zero. o_expire flags the cycle in
//               which the count would reach TIMEOUT, so the loader aborts
//               after exactly TIMEOUT idle cycles. An accept in that same
//               cycle suppresses the expiry. TIMEOUT = 0 disables it.
//   clk      : clock, rising edge
//   reset    : asynchronous, active-high
//   i_run    : counting enabled (loader is inside a frame)
//   i_clear  : a byte was accepted this cycle
//   o_expire : idle limit reached this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module srp16_boot_timeout #(
    parameter int TIMEOUT = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_run,
    input  logic i_clear,
    output logic o_expire
);

    generate
        if (TIMEOUT == 0) begin : g_disabled
            assign o_expire = 1'b0;
        end else begin : g_counter
            localparam int               c_cnt_w = $clog2(TIMEOUT + 1);
            localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(TIMEOUT - 1);

            logic [c_cnt_w-1:0] r_count;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_count <= '0;
                end else if (!i_run || i_clear) begin
                    r_count <= '0;
                end else begin
                    r_count <= r_count + c_cnt_w'(1);
                end
            end

            // Expiry is decided on the edge that would make the count reach
            // TIMEOUT; an accept on that edge takes precedence.
            assign o_expire = i_run && !i_clear && (r_count == c_last);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/srp16_boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : srp16_boot_loader
// Description : Receives a framed program image (LEN_LO, LEN_HI, N payload
//               bytes, 8-bit additive checksum) and writes the payload into
//               byte-wide program memory starting at LOAD_BASE. The SRP16
//               core is held in reset until a frame with a matching checksum
//               has loaded.
//   clk       : clock, rising edge
//   reset     : asynchronous, active-high
//   bus       : byte stream in / memory write out (slave modport)
//   reload    : one-cycle restart request, honoured in RUN and ERROR only
//   cpu_reset : processor reset, high whenever not in RUN
//   done      : high in RUN
//   error     : high in ERROR
//   err_code  : 0 none, 1 length too large, 2 checksum mismatch, 3 timeout
// Revision    : 1.0 - initial release
// ============================================================================
module srp16_boot_loader
    import srp16_pkg::*;
#(
    parameter logic [15:0] LOAD_BASE = 16'h0000,
    parameter logic [15:0] MAX_LEN   = 16'hFFFF,   // LOAD_BASE + MAX_LEN <= 65536
    parameter int          TIMEOUT   = 1000000     // 0 disables the timeout
) (
    input  logic              clk,
    input  logic              reset,
    srp16_boot_loader_if.slave bus,
    input  logic              reload,
    output logic              cpu_reset,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code
);

    logic [STATE_W-1:0] r_state;
    logic [7:0]         r_len_lo;
    logic [15:0]        r_remaining;
    logic [15:0]        r_ptr;
    logic [7:0]         r_csum;

    logic               r_rx_ready;
    logic [15:0]        r_mem_addr;
    logic [7:0]         r_mem_data;
    logic               r_mem_write;
    logic               r_cpu_reset;
    logic               r_done;
    logic               r_error;
    logic [1:0]         r_err_code;

    logic               w_accept;
    logic               w_timed;
    logic               w_expire;
    logic [15:0]        w_len;

    assign w_accept = bus.rx_valid && r_rx_ready;
    assign w_timed  = (r_state == LEN_HI) || (r_state == PAYLOAD) || (r_state == CHECK);
    assign w_len    = {bus.rx_data, r_len_lo};

    srp16_boot_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .i_run    (w_timed),
        .i_clear  (w_accept),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= LEN_LO;
            r_len_lo    <= 8'h00;
            r_remaining <= 16'h0000;
            r_ptr       <= LOAD_BASE;
            r_csum      <= 8'h00;
            r_rx_ready  <= 1'b1;
            r_mem_addr  <= LOAD_BASE;
            r_mem_data  <= 8'h00;
            r_mem_write <= 1'b0;
            r_cpu_reset <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_err_code  <= ERR_NONE;
        end else begin
            // Write strobe is a single-cycle pulse per accepted payload byte.
            r_mem_write <= 1'b0;

            if (w_expire) begin
                // Only asserted inside a frame and never alongside an accept.
                r_state    <= ERROR;
                r_rx_ready <= 1'b0;
                r_error    <= 1'b1;
                r_err_code <= ERR_TIMEOUT;
            end else begin
                case (r_state)
                    LEN_LO: begin
                        if (w_accept) begin
                            r_len_lo <= bus.rx_data;
                            r_state  <= LEN_HI;
                        end
                    end

                    LEN_HI: begin
                        if (w_accept) begin
                            r_csum <= 8'h00;
                            if (w_len > MAX_LEN) begin
                                r_state    <= ERROR;
                                r_rx_ready <= 1'b0;
                                r_error    <= 1'b1;
                                r_err_code <= ERR_LEN;
                            end else if (w_len == 16'h0000) begin
                                r_state <= CHECK;
                            end else begin
                                r_state     <= PAYLOAD;
                                r_remaining <= w_len;
                                r_ptr       <= LOAD_BASE;
                            end
                        end
                    end

                    PAYLOAD: begin
                        if (w_accept) begin
                            r_mem_write <= 1'b1;
                            r_mem_addr  <= r_ptr;
                            r_mem_data  <= bus.rx_data;
                            r_ptr       <= r_ptr + 16'd1;
                            r_csum      <= r_csum + bus.rx_data;
                            r_remaining <= r_remaining - 16'd1;
                            if (r_remaining == 16'd1) begin
                                r_state <= CHECK;
                            end
                        end
                    end

                    CHECK: begin
                        if (w_accept) begin
                            r_rx_ready <= 1'b0;
                            if (bus.rx_data == r_csum) begin
                                r_state     <= RUN;
                                r_cpu_reset <= 1'b0;
                                r_done      <= 1'b1;
                            end else begin
                                r_state    <= ERROR;
                                r_error    <= 1'b1;
                                r_err_code <= ERR_CSUM;
                            end
                        end
                    end

                    RUN: begin
                        if (reload) begin
                            r_state     <= LEN_LO;
                            r_rx_ready  <= 1'b1;
                            r_cpu_reset <= 1'b1;
                            r_done      <= 1'b0;
                        end
                    end

                    ERROR: begin
                        if (reload) begin
                            r_state    <= LEN_LO;
                            r_rx_ready <= 1'b1;
                            r_error    <= 1'b0;
                            r_err_code <= ERR_NONE;
                        end
                    end

                    default: begin
                        // Unreachable encodings fall back to a safe idle.
                        r_state     <= LEN_LO;
                        r_rx_ready  <= 1'b1;
                        r_cpu_reset <= 1'b1;
                        r_done      <= 1'b0;
                        r_error     <= 1'b0;
                        r_err_code  <= ERR_NONE;
                    end
                endcase
            end
        end
    end

    assign bus.rx_ready  = r_rx_ready;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_data  = r_mem_data;
    assign bus.mem_write = r_mem_write;
    assign cpu_reset     = r_cpu_reset;
    assign done          = r_done;
    assign error         = r_error;
    assign err_code      = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_srp16_boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_srp16_boot_loader
// Description : Self-checking bench for srp16_boot_loader. Directed frames
//               cover the normal load, checksum/length/timeout aborts, the
//               accept-beats-timeout corner, asynchronous reset mid-frame and
//               ignored bytes in RUN; randomized frames follow, checked
//               against a frame-level model (expected writes and outcome).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_srp16_boot_loader;

    localparam logic [15:0] LOAD_BASE = 16'h0100;
    localparam logic [15:0] MAX_LEN   = 16'd16;
    localparam int          TIMEOUT   = 10;

    // Expected {rx_ready, cpu_reset, done, error, err_code}
    localparam logic [5:0] ST_LOAD = 6'b110000;
    localparam logic [5:0] ST_RUN  = 6'b001000;

    logic       clk = 1'b0;
    logic       reset;
    logic       reload;
    logic       cpu_reset;
    logic       done;
    logic       error;
    logic [1:0] err_code;

    srp16_boot_loader_if bus ();

    srp16_boot_loader #(
        .LOAD_BASE (LOAD_BASE),
        .MAX_LEN   (MAX_LEN),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .reload    (reload),
        .cpu_reset (cpu_reset),
        .done      (done),
        .error     (error),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [15:0] wr_addr[$];
    logic [7:0]  wr_data[$];
    int          wr_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Memory-write monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (bus.mem_write === 1'b1) begin
            wr_addr.push_back(bus.mem_addr);
            wr_data.push_back(bus.mem_data);
            wr_cyc.push_back(cyc);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] status();
        return {bus.rx_ready, cpu_reset, done, error, err_code};
    endfunction

    function automatic logic [5:0] st_err(input logic [1:0] code);
        return {4'b0101, code};
    endfunction

    task automatic wr_clear();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
    endtask

    // Present one byte after 'gap' idle edges; returns 1 time unit after the
    // edge on which it was offered.
    task automatic drive_byte(input logic [7:0] b, input int gap);
        bus.rx_valid = 1'b0;
        if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
        end
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
    endtask

    // Model: payload byte i lands at LOAD_BASE + i, in order, once each.
    task automatic check_writes(input string tag, input logic [7:0] exp[$]);
        chk({tag, "_wr_count"}, 32'(wr_addr.size()), 32'(exp.size()));
        foreach (exp[i]) begin
            if (i < wr_addr.size()) begin
                chk({tag, "_wr_entry"}, {8'h00, wr_addr[i], wr_data[i]},
                    {8'h00, LOAD_BASE + 16'(i), exp[i]});
            end
        end
    endtask

    initial begin
        logic [7:0] fr[$];
        logic [7:0] pl[$];
        logic [7:0] sum;
        logic [7:0] b;
        int         len;
        int         g;
        bit         good;

        reset        = 1'b1;
        reload       = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_status", 32'(status()), 32'(ST_LOAD));
        chk("reset_addr", 32'(bus.mem_addr), 32'(LOAD_BASE));
        chk("reset_wr_data", 32'({bus.mem_write, bus.mem_data}), 32'h0);
        reset = 1'b0;

        // Normal frame, back-to-back bytes.
        wr_clear();
        fr = '{8'h03, 8'h00, 8'h11, 8'h22, 8'h33};
        foreach (fr[i]) drive_byte(fr[i], 0);
        chk("held_before_csum", 32'(cpu_reset), 32'd1);
        drive_byte(8'h66, 0);
        chk("run_right_after_csum", 32'(status()), 32'(ST_RUN));
        @(negedge clk);
        pl = '{8'h11, 8'h22, 8'h33};
        check_writes("normal", pl);
        if (wr_cyc.size() == 3) begin
            chk("wr_consecutive_1", 32'(wr_cyc[1] - wr_cyc[0]), 32'd1);
            chk("wr_consecutive_2", 32'(wr_cyc[2] - wr_cyc[1]), 32'd1);
        end

        // Bad checksum.
        pulse_reload();
        @(negedge clk);
        chk("reload_from_run", 32'(status()), 32'(ST_LOAD));
        wr_clear();
        foreach (fr[i]) drive_byte(fr[i], 0);
        drive_byte(8'h67, 0);
        @(negedge clk);
        chk("csum_error", 32'(status()), 32'(st_err(2'd2)));
        check_writes("badcsum", pl);
        pulse_reload();
        @(negedge clk);
        chk("reload_from_error", 32'(status()), 32'(ST_LOAD));

        // Length above MAX_LEN.
        wr_clear();
        drive_byte(8'h20, 0);
        drive_byte(8'h00, 0);
        @(negedge clk);
        chk("len_error", 32'(status()), 32'(st_err(2'd1)));
        pl = {};
        check_writes("len", pl);
        pulse_reload();

        // Accept on the edge that would time out wins (twice).
        wr_clear();
        drive_byte(8'h02, 0);
        drive_byte(8'h00, 0);
        drive_byte(8'hAA, 0);
        repeat (TIMEOUT - 1) @(posedge clk);
        @(negedge clk);
        chk("idle_below_limit", 32'(status()), 32'(ST_LOAD));
        drive_byte(8'hBB, 0);
        drive_byte(8'h65, TIMEOUT - 1);
        @(negedge clk);
        chk("accept_beats_timeout", 32'(status()), 32'(ST_RUN));
        pl = '{8'hAA, 8'hBB};
        check_writes("to_edge", pl);
        pulse_reload();

        // Genuine timeout after TIMEOUT idle cycles.
        wr_clear();
        drive_byte(8'h02, 0);
        drive_byte(8'h00, 0);
        drive_byte(8'hAA, 0);
        repeat (TIMEOUT - 1) @(posedge clk);
        @(negedge clk);
        chk("timeout_not_yet", 32'(error), 32'd0);
        @(negedge clk);
        chk("timeout_error", 32'(status()), 32'(st_err(2'd3)));
        pl = '{8'hAA};
        check_writes("timeout", pl);
        pulse_reload();

        // Empty payload.
        wr_clear();
        drive_byte(8'h00, 0);
        drive_byte(8'h00, 0);
        drive_byte(8'h00, 0);
        @(negedge clk);
        chk("empty_run", 32'(status()), 32'(ST_RUN));
        pl = {};
        check_writes("empty", pl);
        pulse_reload();

        // Asynchronous reset in the middle of a frame.
        drive_byte(8'h01, 0);
        drive_byte(8'h00, 0);
        drive_byte(8'h55, 0);
        chk("pre_reset_write", 32'({bus.mem_write, bus.mem_data}), 32'h155);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_status", 32'(status()), 32'(ST_LOAD));
        chk("async_reset_bus", 32'({bus.mem_write, bus.mem_addr, bus.mem_data}),
            32'({1'b0, LOAD_BASE, 8'h00}));
        @(negedge clk);
        reset = 1'b0;
        wr_clear();
        fr = '{8'h01, 8'h00, 8'h77, 8'h77};
        foreach (fr[i]) drive_byte(fr[i], 0);
        @(negedge clk);
        chk("restart_after_reset", 32'(status()), 32'(ST_RUN));
        pl = '{8'h77};
        check_writes("restart", pl);

        // rx_valid toggling every other cycle; then bytes in RUN are ignored.
        pulse_reload();
        wr_clear();
        fr = '{8'h01, 8'h00, 8'hFF, 8'hFF};
        foreach (fr[i]) drive_byte(fr[i], 1);
        @(negedge clk);
        chk("toggle_run", 32'(status()), 32'(ST_RUN));
        pl = '{8'hFF};
        check_writes("toggle", pl);
        wr_clear();
        drive_byte(8'h03, 0);
        drive_byte(8'h00, 0);
        drive_byte(8'h12, 0);
        drive_byte(8'h34, 1);
        @(negedge clk);
        chk("run_ignores_bytes", 32'(status()), 32'(ST_RUN));
        pl = {};
        check_writes("run_ignore", pl);

        // Randomized frames against the frame-level model.
        for (int k = 0; k < 24; k++) begin
            pulse_reload();
            wr_clear();
            len = int'($urandom_range(0, 20));
            pl  = {};
            sum = 8'h00;
            for (int i = 0; i < len; i++) begin
                b = 8'($urandom_range(0, 255));
                pl.push_back(b);
                sum = sum + b;
            end
            g = ($urandom_range(0, 7) == 0) ? TIMEOUT - 1 : int'($urandom_range(0, 2));
            drive_byte(8'(len), g);
            g = ($urandom_range(0, 7) == 0) ? TIMEOUT - 1 : int'($urandom_range(0, 2));
            drive_byte(8'h00, g);
            if (len > int'(MAX_LEN)) begin
                @(negedge clk);
                chk("rand_len_error", 32'(status()), 32'(st_err(2'd1)));
                pl = {};
                check_writes("rand_len", pl);
            end else begin
                foreach (pl[i]) begin
                    g = ($urandom_range(0, 7) == 0) ? TIMEOUT - 1 : int'($urandom_range(0, 2));
                    drive_byte(pl[i], g);
                end
                good = ($urandom_range(0, 3) != 0);
                b    = good ? sum : (sum ^ 8'($urandom_range(1, 255)));
                drive_byte(b, int'($urandom_range(0, 3)));
                @(negedge clk);
                chk("rand_outcome", 32'(status()), good ? 32'(ST_RUN) : 32'(st_err(2'd2)));
                check_writes("rand", pl);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
